data_mem_port: RTL and testbench
================================

Name: data_mem_port

Overview:
- Downstream stage of the memory control block: consumes its LDR, STR, RW, add_bus and data_bus outputs.
- Performs the word access on an internal data RAM with a configurable number of wait states.
- Returns load data and a one-cycle completion pulse, which feed the LDR writeback path.
- Accepts one request at a time. Requests that arrive while busy are dropped; the issuer must hold or reissue them.

Parameters:
- DATA_W, 32, data word width
- ADDR_W, 8, RAM word-address width; depth = 2**ADDR_W
- WAIT_CYCLES, 2, wait states inserted before the RAM access (0..15)

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- LDR  in  1  load request (level, sampled in IDLE)
- STR  in  1  store request (level, sampled in IDLE)
- RW  in  1  1 = read, 0 = write; must agree with LDR/STR
- add_bus  in  32  word address; only [ADDR_W-1:0] indexes the RAM
- data_bus  in  DATA_W  store data
- load_data  out  DATA_W  read result; holds its value until the next successful load
- mem_ready  out  1  one-cycle completion pulse (success or error)
- mem_busy  out  1  high from the accept edge until the edge that returns to IDLE
- mem_error  out  1  qualifies mem_ready: request rejected

Behaviour:
- Reset (Reset=0, asynchronous):
  - state=IDLE, wait counter=0, load_data=0, mem_ready=0, mem_busy=0, mem_error=0, captured registers=0.
  - RAM contents are not reset. They are retained across reset and undefined at power-up.
- States: IDLE, WAIT, ACCESS, RESP, ERR.
- IDLE:
  - A request is sampled at a rising edge when LDR|STR=1.
  - Valid request: exactly one of LDR/STR high, RW==LDR, and add_bus[31:ADDR_W]==0.
  - On a valid request, capture op, address and data_bus, and set mem_busy=1.
  - Go to WAIT if WAIT_CYCLES>0, else go to ACCESS.
  - On an invalid request (LDR&STR, RW mismatch, or address out of range), go to ERR. No capture of data; RAM untouched.
- WAIT:
  - Counter loads WAIT_CYCLES-1 on entry and decrements each edge.
  - Go to ACCESS on the edge where the counter is 0. This gives exactly WAIT_CYCLES cycles in WAIT.
- ACCESS (one cycle):
  - Store: RAM[addr] <= captured data at the exiting edge.
  - Load: load_data <= RAM[addr] at the exiting edge.
  - Go to RESP.
- RESP (one cycle): mem_ready=1, mem_error=0, then go to IDLE and drop mem_busy.
- ERR (one cycle): mem_ready=1, mem_error=1, load_data unchanged, then go to IDLE.
- Latency: from the accept edge to the first cycle with mem_ready=1 is WAIT_CYCLES+2 edges. Error latency is 1 edge.
- Inputs seen outside IDLE are ignored: no queueing, no error.
- Back-to-back requests: with request levels held, the earliest next accept is the edge that leaves RESP/ERR. That edge samples the inputs in IDLE, so a held request is accepted there.
- Load data path: load_data changes only on a successful load.
- Read-after-write to the same address returns the new data, because the accesses are separate.
- Reset mid-operation:
  - Any state returns to IDLE immediately.
  - A store whose ACCESS edge has not occurred is not performed.
  - mem_ready is not emitted.
- Address wrap: none. Upper address bits must be zero, else the request errors.
- The RAM is a single-port synchronous array with no combinational read path to the outputs.

Test Plan:
- Reset released, WAIT_CYCLES=2, STR=1 RW=0 add_bus=0x05 data_bus=0xDEADBEEF:
  - mem_busy rises at the accept edge.
  - mem_ready=1, mem_error=0 exactly 4 edges after accept.
  - Then LDR=1 RW=1 add_bus=0x05 gives load_data=0xDEADBEEF with mem_ready 4 edges after accept.
- WAIT_CYCLES=0 build: load from address 0xFF after a store of 0x12345678 gives mem_ready 2 edges after accept, load_data=0x12345678.
- LDR=1 STR=1 gives mem_ready=1, mem_error=1 one edge later, and load_data unchanged.
- Separately, LDR=1 RW=0 errors in the same way.
- Separately, add_bus=0x100 errors in the same way, and a follow-up load of 0x00 shows that address unmodified.
- STR to 0x10 accepted; a second STR to 0x11 with value 0xAAAA0000 is driven during WAIT and dropped, with no second mem_ready. A load of 0x11 returns the prior value.
- STR of 0xCAFEF00D to 0x20 (previously 0x0); Reset pulsed low during WAIT:
  - All outputs are 0 immediately and no mem_ready is produced.
  - A subsequent load of 0x20 returns 0x0.

Source files
------------

// File: rtl/data_mem_port.sv
// data_mem_port
// Sits downstream of the memory control block. It takes one LDR/STR word
// request at a time and performs it on an internal single-port data RAM
// after WAIT_CYCLES wait states. It returns the load data together with a
// one-cycle completion pulse, and that pulse feeds the LDR writeback path.
//
// Ports:
//   Clk        system clock, rising edge
//   Reset      asynchronous, active-low reset
//   LDR, STR   load / store request levels, sampled only in IDLE
//   RW         1 = read, 0 = write; must agree with LDR/STR
//   add_bus    word address; the upper bits above ADDR_W must be zero
//   data_bus   store data
//   load_data  last successful load result, held until the next one
//   mem_ready  one-cycle completion pulse (success or error)
//   mem_busy   high from the accept edge until the edge back to IDLE
//   mem_error  qualifies mem_ready: the request was rejected
module data_mem_port #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              LDR,
    input  logic              STR,
    input  logic              RW,
    input  logic [31:0]       add_bus,
    input  logic [DATA_W-1:0] data_bus,
    output logic [DATA_W-1:0] load_data,
    output logic              mem_ready,
    output logic              mem_busy,
    output logic              mem_error
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP,
        ST_ERR
    } state_t;

    // The counter counts down to zero, so it starts at WAIT_CYCLES-1.
    // That keeps the FSM in WAIT for exactly WAIT_CYCLES cycles.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t              state;
    logic [3:0]          wait_cnt;
    logic                op_load;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   ram [0:(2**ADDR_W)-1];

    logic                req_seen;
    logic                req_valid;

    // A request is well formed only if all of these hold:
    //   - exactly one of LDR/STR is high,
    //   - the direction on RW matches that request,
    //   - the address is in range (there is no wrap).
    always_comb begin
        req_seen  = LDR | STR;
        req_valid = (LDR ^ STR) && (RW == LDR) && (add_bus[31:ADDR_W] == '0);
    end

    // Control FSM. All outputs are registered.
    // mem_ready defaults low, so it is only high for the single cycle
    // spent in RESP or ERR.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= 4'd0;
            op_load   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            load_data <= '0;
            mem_ready <= 1'b0;
            mem_busy  <= 1'b0;
            mem_error <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            mem_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_seen) begin
                        if (req_valid) begin
                            op_load  <= LDR;
                            addr_q   <= add_bus[ADDR_W-1:0];
                            data_q   <= data_bus;
                            mem_busy <= 1'b1;
                            if (WAIT_CYCLES > 0) begin
                                state    <= ST_WAIT;
                                wait_cnt <= WAIT_LOAD;
                            end else begin
                                state <= ST_ACCESS;
                            end
                        end else begin
                            state     <= ST_ERR;
                            mem_ready <= 1'b1;
                            mem_error <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= ST_ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    if (op_load) begin
                        load_data <= ram[addr_q];
                    end
                    mem_ready <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    mem_busy <= 1'b0;
                    state    <= ST_IDLE;
                end
                ST_ERR: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM write port. The array has no reset, so its contents survive a
    // reset. The write is also gated on Reset: a store caught by a reset
    // on its ACCESS edge must never land in the array.
    always_ff @(posedge Clk) begin
        if (Reset && (state == ST_ACCESS) && !op_load) begin
            ram[addr_q] <= data_q;
        end
    end

endmodule

// File: tb/tb_data_mem_port.sv
// tb_data_mem_port
// Drives two data_mem_port instances: index 0 uses the default two wait
// states and index 1 uses zero wait states. Directed scenarios are mixed
// with random requests. Every result is compared against a word-level
// memory model and the request-validity rules.
module tb_data_mem_port;

    logic        clk;
    logic        rstN;
    logic        ldr      [2];
    logic        str      [2];
    logic        rw       [2];
    logic [31:0] addrBus  [2];
    logic [31:0] dataBus  [2];
    logic [31:0] loadData [2];
    logic        ready    [2];
    logic        busy     [2];
    logic        err      [2];

    int          vectors;
    int          miscompares;

    // Behavioural model, one slot per instance.
    logic [31:0] memModel  [2][256];
    bit          memKnown  [2][256];
    logic [31:0] lastLoad  [2];
    bit          lastKnown [2];
    int          waitsOf   [2];

    data_mem_port #(.DATA_W(32), .ADDR_W(8), .WAIT_CYCLES(2)) dutSlow (
        .Clk(clk), .Reset(rstN), .LDR(ldr[0]), .STR(str[0]), .RW(rw[0]),
        .add_bus(addrBus[0]), .data_bus(dataBus[0]), .load_data(loadData[0]),
        .mem_ready(ready[0]), .mem_busy(busy[0]), .mem_error(err[0])
    );

    data_mem_port #(.DATA_W(32), .ADDR_W(8), .WAIT_CYCLES(0)) dutFast (
        .Clk(clk), .Reset(rstN), .LDR(ldr[1]), .STR(str[1]), .RW(rw[1]),
        .add_bus(addrBus[1]), .data_bus(dataBus[1]), .load_data(loadData[1]),
        .mem_ready(ready[1]), .mem_busy(busy[1]), .mem_error(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports it if the values differ.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drives one request level onto instance d.
    task automatic driveInputs(input int d, input logic l, input logic s, input logic r,
                               input logic [31:0] a, input logic [31:0] v);
        ldr[d]     = l;
        str[d]     = s;
        rw[d]      = r;
        addrBus[d] = a;
        dataBus[d] = v;
    endtask

    // Applies one full request to instance d and checks the accept
    // behaviour, latency, error flag, load data and the return to idle.
    // Latency counts the accept edge as the first edge, so mem_ready shows
    // up waits+1 edges after it for a good request, or straight after the
    // accept edge for a rejected one.
    task automatic applyStimulus(input int d, input logic l, input logic s, input logic r,
                                 input logic [31:0] a, input logic [31:0] v);
        bit valid;
        int n;
        valid = (l ^ s) && (r == l) && (a < 32'd256);
        @(negedge clk);
        driveInputs(d, l, s, r, a, v);
        @(posedge clk);
        #1;
        driveInputs(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        if (valid) checkOutput("busy_at_accept", 32'(busy[d]), 32'd1);
        n = 0;
        while (!ready[d] && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("latency", 32'(n), valid ? 32'(waitsOf[d] + 1) : 32'd0);
        checkOutput("error_flag", 32'(err[d]), valid ? 32'd0 : 32'd1);
        if (valid && s) begin
            memModel[d][a[7:0]] = v;
            memKnown[d][a[7:0]] = 1'b1;
        end
        if (valid && l) begin
            lastLoad[d]  = memModel[d][a[7:0]];
            lastKnown[d] = memKnown[d][a[7:0]];
        end
        if (lastKnown[d]) checkOutput("load_data", loadData[d], lastLoad[d]);
        @(posedge clk);
        #1;
        checkOutput("ready_one_cycle", 32'(ready[d]), 32'd0);
        checkOutput("busy_idle", 32'(busy[d]), 32'd0);
    endtask

    // Counts mem_ready pulses on instance d over a window of cycles.
    task automatic countReady(input int d, input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            if (ready[d]) cnt++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int cnt;
        int d;
        int k;
        logic        l;
        logic        s;
        logic        r;
        logic [31:0] a;
        logic [31:0] v;

        vectors     = 0;
        miscompares = 0;
        waitsOf[0]  = 2;
        waitsOf[1]  = 0;
        for (int i = 0; i < 2; i++) begin
            driveInputs(i, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            lastLoad[i]  = 32'h0;
            lastKnown[i] = 1'b1;
            for (int j = 0; j < 256; j++) begin
                memModel[i][j] = 32'h0;
                memKnown[i][j] = 1'b0;
            end
        end

        // Reset state
        rstN = 1'b0;
        #12;
        for (int i = 0; i < 2; i++) begin
            checkOutput("reset_load_data", loadData[i], 32'h0);
            checkOutput("reset_ready", 32'(ready[i]), 32'd0);
            checkOutput("reset_busy", 32'(busy[i]), 32'd0);
            checkOutput("reset_error", 32'(err[i]), 32'd0);
        end
        @(negedge clk);
        rstN = 1'b1;

        // Give the low addresses known contents in both instances
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 32; j++) begin
                applyStimulus(i, 1'b0, 1'b1, 1'b0, 32'(j), $urandom);
            end
        end

        // Store then load, two wait states
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 32'h05, 32'hDEADBEEF);
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 32'h05, 32'h0);

        // Zero wait states, top address
        applyStimulus(1, 1'b0, 1'b1, 1'b0, 32'hFF, 32'h12345678);
        applyStimulus(1, 1'b1, 1'b0, 1'b1, 32'hFF, 32'h0);

        // Rejected requests
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 32'h05, 32'h11111111);
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'h05, 32'h22222222);
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h33333333);
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 32'h00, 32'h0);

        // A second store issued during WAIT is dropped
        v = $urandom;
        @(negedge clk);
        driveInputs(0, 1'b0, 1'b1, 1'b0, 32'h10, v);
        @(posedge clk);
        #1;
        driveInputs(0, 1'b0, 1'b1, 1'b0, 32'h11, 32'hAAAA0000);
        @(posedge clk);
        #1;
        driveInputs(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        countReady(0, 12, cnt);
        checkOutput("drop_single_ready", 32'(cnt), 32'd1);
        memModel[0][8'h10] = v;
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 32'h11, 32'h0);
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0);

        // A reset during WAIT cancels the store
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 32'h20, 32'h0);
        @(negedge clk);
        driveInputs(0, 1'b0, 1'b1, 1'b0, 32'h20, 32'hCAFEF00D);
        @(posedge clk);
        #1;
        driveInputs(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("busy_before_reset", 32'(busy[0]), 32'd1);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("midreset_load_data", loadData[0], 32'h0);
        checkOutput("midreset_ready", 32'(ready[0]), 32'd0);
        checkOutput("midreset_busy", 32'(busy[0]), 32'd0);
        checkOutput("midreset_error", 32'(err[0]), 32'd0);
        lastLoad[0] = 32'h0;
        lastKnown[0] = 1'b1;
        lastLoad[1] = 32'h0;
        lastKnown[1] = 1'b1;
        @(negedge clk);
        rstN = 1'b1;
        countReady(0, 8, cnt);
        checkOutput("no_ready_after_reset", 32'(cnt), 32'd0);
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 32'h20, 32'h0);

        // Randomized mix of good and bad requests on both instances
        repeat (80) begin
            d = $urandom_range(0, 1);
            k = $urandom_range(0, 9);
            a = 32'($urandom_range(0, 31));
            v = $urandom;
            l = 1'b0;
            s = 1'b1;
            r = 1'b0;
            if (k >= 4 && k <= 6) begin
                l = 1'b1;
                s = 1'b0;
                r = 1'b1;
            end else if (k == 7) begin
                l = 1'b1;
                s = 1'b1;
                r = 1'($urandom_range(0, 1));
            end else if (k == 8) begin
                l = 1'($urandom_range(0, 1));
                s = ~l;
                r = s;
            end else if (k == 9) begin
                l = 1'($urandom_range(0, 1));
                s = ~l;
                r = l;
                a = a | (32'h100 << $urandom_range(0, 23));
            end
            applyStimulus(d, l, s, r, a, v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
